// File: rtl/tot_pulse_pkg.sv
// -----------------------------------------------------------------------------
// tot_pulse_pkg
// Shared definitions for the calibration pulse generator: the pulser state
// encoding, the default field widths and the minimum inter-pulse gap.
// No ports (package).
// -----------------------------------------------------------------------------
package tot_pulse_pkg;

  localparam int DEF_HIGH_BITS  = 16;
  localparam int DEF_GAP_BITS   = 16;
  localparam int DEF_COUNT_BITS = 16;

  // A programmed gap of zero is stretched to this many low cycles so that
  // consecutive pulses always show a distinct rising edge.
  localparam int MIN_GAP = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Width of a counter shared between two fields of different widths.
  function automatic int max_width(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tot_phase_counter.sv
// -----------------------------------------------------------------------------
// tot_phase_counter
// Loadable down-counter used to time both the high and the gap phase.
// A load strobe places the phase length in the counter; it then counts down
// and parks at 1. terminal is high while the count is 1, i.e. during the last
// cycle of the phase.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset
//   load     in   load strobe (takes priority over counting)
//   load_val in   phase length to load (>= 1 when used)
//   terminal out  last cycle of the current phase
// -----------------------------------------------------------------------------
module tot_phase_counter
  import tot_pulse_pkg::*;
#(
  parameter int WIDTH = DEF_HIGH_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             terminal
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load, otherwise count down to 1 and hold there (never wraps).
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q > WIDTH'(1)) begin
      count_d = count_q - WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == WIDTH'(1));

endmodule

// File: rtl/tot_pulse_generator.sv
// -----------------------------------------------------------------------------
// tot_pulse_generator
// On-board calibration pulser feeding the SIGNAL input of the TOT calculators.
// On START (in IDLE) it latches the configuration and emits PULSE_COUNT pulses,
// each HIGH_CYCLES high, separated by max(GAP_CYCLES,1) low cycles.
// Ports:
//   CLK          in   fast TOT clock
//   RESET        in   asynchronous active-high reset
//   START        in   start a train (only looked at in IDLE)
//   ABORT        in   stop the current train (wins over START)
//   HIGH_CYCLES  in   high time per pulse
//   GAP_CYCLES   in   low time between pulses
//   PULSE_COUNT  in   pulses per train
//   SIGNAL_OUT   out  registered pulse line
//   BUSY         out  train in progress
//   DONE         out  one-cycle strobe on normal completion
//   PULSES_SENT  out  fully completed pulses in the current/last train
// -----------------------------------------------------------------------------
module tot_pulse_generator
  import tot_pulse_pkg::*;
#(
  parameter int HIGH_BITS  = DEF_HIGH_BITS,
  parameter int GAP_BITS   = DEF_GAP_BITS,
  parameter int COUNT_BITS = DEF_COUNT_BITS
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [HIGH_BITS-1:0]  HIGH_CYCLES,
  input  logic [GAP_BITS-1:0]   GAP_CYCLES,
  input  logic [COUNT_BITS-1:0] PULSE_COUNT,
  output logic                  SIGNAL_OUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [COUNT_BITS-1:0] PULSES_SENT
);

  localparam int PHASE_BITS = max_width(HIGH_BITS, GAP_BITS);

  state_e                state_q, state_d;
  logic                  signal_q, signal_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [COUNT_BITS-1:0] pulses_sent_q, pulses_sent_d;
  logic [COUNT_BITS-1:0] remaining_q, remaining_d;
  logic [COUNT_BITS-1:0] count_len_q, count_len_d;
  logic [HIGH_BITS-1:0]  high_len_q, high_len_d;
  logic [GAP_BITS-1:0]   gap_len_q, gap_len_d;

  logic                  phase_load_s;
  logic [PHASE_BITS-1:0] phase_load_val_s;
  logic                  phase_terminal_s;
  logic [GAP_BITS-1:0]   gap_eff_s;

  assign gap_eff_s = (gap_len_q < GAP_BITS'(MIN_GAP)) ? GAP_BITS'(MIN_GAP) : gap_len_q;

  tot_phase_counter #(
    .WIDTH (PHASE_BITS)
  ) u_phase_counter (
    .clk      (CLK),
    .rst      (RESET),
    .load     (phase_load_s),
    .load_val (phase_load_val_s),
    .terminal (phase_terminal_s)
  );

  // Next-state and next-output logic of the pulser.
  always_comb begin
    state_d          = state_q;
    signal_d         = signal_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    pulses_sent_d    = pulses_sent_q;
    remaining_d      = remaining_q;
    count_len_d      = count_len_q;
    high_len_d       = high_len_q;
    gap_len_d        = gap_len_q;
    phase_load_s     = 1'b0;
    phase_load_val_s = PHASE_BITS'(high_len_q);

    case (state_q)
      ST_IDLE: begin
        if (START && !ABORT) begin
          high_len_d    = HIGH_CYCLES;
          gap_len_d     = GAP_CYCLES;
          count_len_d   = PULSE_COUNT;
          pulses_sent_d = {COUNT_BITS{1'b0}};
          if ((HIGH_CYCLES == {HIGH_BITS{1'b0}}) || (PULSE_COUNT == {COUNT_BITS{1'b0}})) begin
            // Empty train: report completion without ever going busy.
            done_d = 1'b1;
          end else begin
            state_d          = ST_HIGH;
            signal_d         = 1'b1;
            busy_d           = 1'b1;
            remaining_d      = PULSE_COUNT;
            phase_load_s     = 1'b1;
            phase_load_val_s = PHASE_BITS'(HIGH_CYCLES);
          end
        end else begin
          state_d  = ST_IDLE;
          signal_d = 1'b0;
          busy_d   = 1'b0;
        end
      end

      ST_HIGH: begin
        if (ABORT) begin
          // Truncated pulse is not counted.
          state_d  = ST_IDLE;
          signal_d = 1'b0;
          busy_d   = 1'b0;
        end else if (phase_terminal_s) begin
          signal_d      = 1'b0;
          remaining_d   = remaining_q - COUNT_BITS'(1);
          pulses_sent_d = (pulses_sent_q < count_len_q) ? (pulses_sent_q + COUNT_BITS'(1))
                                                        : pulses_sent_q;
          if (remaining_q == COUNT_BITS'(1)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d          = ST_GAP;
            phase_load_s     = 1'b1;
            phase_load_val_s = PHASE_BITS'(gap_eff_s);
          end
        end else begin
          signal_d = 1'b1;
        end
      end

      ST_GAP: begin
        if (ABORT) begin
          state_d  = ST_IDLE;
          signal_d = 1'b0;
          busy_d   = 1'b0;
        end else if (phase_terminal_s) begin
          state_d          = ST_HIGH;
          signal_d         = 1'b1;
          phase_load_s     = 1'b1;
          phase_load_val_s = PHASE_BITS'(high_len_q);
        end else begin
          signal_d = 1'b0;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        signal_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State, configuration and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      signal_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pulses_sent_q <= {COUNT_BITS{1'b0}};
      remaining_q   <= {COUNT_BITS{1'b0}};
      count_len_q   <= {COUNT_BITS{1'b0}};
      high_len_q    <= {HIGH_BITS{1'b0}};
      gap_len_q     <= {GAP_BITS{1'b0}};
    end else begin
      state_q       <= state_d;
      signal_q      <= signal_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pulses_sent_q <= pulses_sent_d;
      remaining_q   <= remaining_d;
      count_len_q   <= count_len_d;
      high_len_q    <= high_len_d;
      gap_len_q     <= gap_len_d;
    end
  end

  assign SIGNAL_OUT  = signal_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign PULSES_SENT = pulses_sent_q;

endmodule

// File: tb/tb_tot_pulse_generator.sv
// -----------------------------------------------------------------------------
// tb_tot_pulse_generator
// Self-checking bench for tot_pulse_generator. Expected per-cycle outputs of a
// train are generated as a list of cycles from the pulse-train description
// (high run, gap run, completion cycle) and compared cycle by cycle.
// -----------------------------------------------------------------------------
module tb_tot_pulse_generator;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic        ABORT;
  logic [15:0] HIGH_CYCLES;
  logic [15:0] GAP_CYCLES;
  logic [15:0] PULSE_COUNT;
  logic        SIGNAL_OUT;
  logic        BUSY;
  logic        DONE;
  logic [15:0] PULSES_SENT;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        sig;
    logic        busy;
    logic        done;
    logic [15:0] sent;
  } obs_t;

  obs_t exp_q[$];

  always #5 CLK = ~CLK;

  tot_pulse_generator dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .START       (START),
    .ABORT       (ABORT),
    .HIGH_CYCLES (HIGH_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES),
    .PULSE_COUNT (PULSE_COUNT),
    .SIGNAL_OUT  (SIGNAL_OUT),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .PULSES_SENT (PULSES_SENT)
  );

  function automatic obs_t mk(input logic s, input logic b, input logic d, input int p);
    obs_t o;
    o.sig  = s;
    o.busy = b;
    o.done = d;
    o.sent = 16'(p);
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.sig  = SIGNAL_OUT;
    o.busy = BUSY;
    o.done = DONE;
    o.sent = PULSES_SENT;
    return o;
  endfunction

  task automatic chk(input string tag, input obs_t obs, input obs_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed sig=%b busy=%b done=%b sent=%0d expected sig=%b busy=%b done=%b sent=%0d",
             tag, obs.sig, obs.busy, obs.done, obs.sent, exp.sig, exp.busy, exp.done, exp.sent);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Expected outputs for each cycle after START, from the train description.
  task automatic build_trace(input int h, input int g, input int n);
    int geff;
    exp_q.delete();
    geff = (g < 1) ? 1 : g;
    if (h == 0 || n == 0) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 0));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 0));
    end else begin
      for (int p = 0; p < n; p++) begin
        for (int c = 0; c < h; c++) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, p));
        if (p < n - 1) begin
          for (int c = 0; c < geff; c++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, p + 1));
        end
      end
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, n));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, n));
    end
  endtask

  // Start a train, optionally abort at / re-request START at a trace index.
  task automatic run_train(input string tag, input int h, input int g, input int n,
                           input int abort_at, input int restart_at, output int busy_cycles);
    obs_t cut;
    build_trace(h, g, n);
    if (abort_at >= 0) begin
      cut = exp_q[abort_at];
      while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, int'(cut.sent)));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, int'(cut.sent)));
    end
    HIGH_CYCLES = 16'(h);
    GAP_CYCLES  = 16'(g);
    PULSE_COUNT = 16'(n);
    ABORT = 1'b0;
    START = 1'b1;
    step();
    START = 1'b0;
    // Configuration must have been latched; scramble the inputs.
    HIGH_CYCLES = 16'($urandom);
    GAP_CYCLES  = 16'($urandom);
    PULSE_COUNT = 16'($urandom);
    busy_cycles = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s[%0d]", tag, i), sample(), exp_q[i]);
      if (BUSY === 1'b1) busy_cycles++;
      ABORT = (i == abort_at);
      START = (i == restart_at);
      step();
    end
    ABORT = 1'b0;
    START = 1'b0;
  endtask

  initial begin
    int busy;
    int h, g, n;

    RESET = 1'b1;
    START = 1'b0;
    ABORT = 1'b0;
    HIGH_CYCLES = 16'd0;
    GAP_CYCLES  = 16'd0;
    PULSE_COUNT = 16'd0;
    step();
    step();
    chk("reset_state", sample(), mk(1'b0, 1'b0, 1'b0, 0));
    RESET = 1'b0;
    step();
    chk("after_reset_idle", sample(), mk(1'b0, 1'b0, 1'b0, 0));

    run_train("single_1", 1, 100, 1, -1, -1, busy);
    chk_int("busy_single_1", busy, 1);

    run_train("train_10_5_3", 10, 5, 3, -1, -1, busy);
    chk_int("busy_10_5_3", busy, 40);

    run_train("gap0_2_4", 2, 0, 4, -1, -1, busy);
    chk_int("busy_2_0_4", busy, 11);

    run_train("high_zero", 0, 7, 3, -1, -1, busy);
    chk_int("busy_high_zero", busy, 0);
    run_train("count_zero", 5, 7, 0, -1, -1, busy);
    chk_int("busy_count_zero", busy, 0);

    // Abort in the 3rd high phase (index 85), START while busy at index 5.
    run_train("abort_20_20_5", 20, 20, 5, 85, 5, busy);

    // START together with ABORT in IDLE, then ABORT alone: nothing happens.
    HIGH_CYCLES = 16'd3;
    GAP_CYCLES  = 16'd3;
    PULSE_COUNT = 16'd3;
    START = 1'b1;
    ABORT = 1'b1;
    step();
    START = 1'b0;
    chk("start_abort_idle", sample(), mk(1'b0, 1'b0, 1'b0, 2));
    step();
    chk("start_abort_idle_2", sample(), mk(1'b0, 1'b0, 1'b0, 2));
    ABORT = 1'b0;
    step();
    chk("abort_alone_idle", sample(), mk(1'b0, 1'b0, 1'b0, 2));

    // START in the DONE cycle is accepted.
    HIGH_CYCLES = 16'd1;
    GAP_CYCLES  = 16'd0;
    PULSE_COUNT = 16'd1;
    START = 1'b1;
    step();
    START = 1'b0;
    chk("b2b_first_high", sample(), mk(1'b1, 1'b1, 1'b0, 0));
    step();
    chk("b2b_first_done", sample(), mk(1'b0, 1'b0, 1'b1, 1));
    HIGH_CYCLES = 16'd2;
    START = 1'b1;
    step();
    START = 1'b0;
    chk("b2b_second_high0", sample(), mk(1'b1, 1'b1, 1'b0, 0));
    step();
    chk("b2b_second_high1", sample(), mk(1'b1, 1'b1, 1'b0, 0));
    step();
    chk("b2b_second_done", sample(), mk(1'b0, 1'b0, 1'b1, 1));
    step();
    chk("b2b_idle", sample(), mk(1'b0, 1'b0, 1'b0, 1));

    // Randomized trains.
    for (int k = 0; k < 10; k++) begin
      h = (k == 9) ? 0 : int'($urandom_range(1, 6));
      g = int'($urandom_range(0, 4));
      n = int'($urandom_range(1, 4));
      run_train($sformatf("rand%0d_h%0d_g%0d_n%0d", k, h, g, n), h, g, n, -1, -1, busy);
    end

    // Asynchronous reset in the middle of the second pulse.
    HIGH_CYCLES = 16'd4;
    GAP_CYCLES  = 16'd2;
    PULSE_COUNT = 16'd3;
    START = 1'b1;
    step();
    START = 1'b0;
    repeat (7) step();
    chk("pre_reset_mid_pulse", sample(), mk(1'b1, 1'b1, 1'b0, 1));
    #2;
    RESET = 1'b1;
    #1;
    chk("async_reset_no_edge", sample(), mk(1'b0, 1'b0, 1'b0, 0));
    step();
    chk("reset_held", sample(), mk(1'b0, 1'b0, 1'b0, 0));
    RESET = 1'b0;
    step();
    run_train("after_reset", 3, 1, 2, -1, -1, busy);
    chk_int("busy_after_reset", busy, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
